address_sequencer: RTL

- FSM that drives the control strobes of the 16-bit PC / address-register datapath (pcLoad, pcInc, arLoad, arInc, tlLoad, thLoad, sel).
- Fetches the opcode and an optional two-byte little-endian address operand over a req/ack memory read handshake.
- Then either jumps (loads PC) or loads AR and hands control to the execute unit, which may step AR.
- Sits between the instruction decoder/execute unit and the address datapath; includes a memory-ack watchdog.

---
 rtl/address_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/address_sequencer.sv
// Control FSM for the PC / address-register datapath: fetches opcode plus optional
// little-endian address operand over req/ack, then jumps or loads AR and runs EXEC.
module address_sequencer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mem_ack,
  input  logic [1:0] op_mode,
  input  logic       ar_step,
  input  logic       exec_done,
  output logic       mem_rd,
  output logic       mem_addr_sel,
  output logic       ir_load,
  output logic       pcLoad,
  output logic       pcInc,
  output logic       arLoad,
  output logic       arInc,
  output logic       tlLoad,
  output logic       thLoad,
  output logic       sel,
  output logic       exec_go,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_OP,
    S_FETCH_LO,
    S_FETCH_HI,
    S_LOAD,
    S_EXEC,
    S_FAULT
  } state_e;

  localparam int WDW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           fetch_st;
  logic           wd_expire;

  assign fetch_st  = (state_q == S_FETCH_OP) || (state_q == S_FETCH_LO) || (state_q == S_FETCH_HI);
  // An ack on the last allowed cycle is serviced instead of faulting.
  assign wd_expire = (ACK_TIMEOUT > 0) && fetch_st && !mem_ack && (wd_q == WD_LAST);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    mem_rd       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pcLoad       = 1'b0;
    pcInc        = 1'b0;
    arLoad       = 1'b0;
    arInc        = 1'b0;
    tlLoad       = 1'b0;
    thLoad       = 1'b0;
    sel          = 1'b1;
    exec_go      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH_OP;
      end
      S_FETCH_OP: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pcInc   = 1'b1;
          mode_d  = (op_mode == 2'b11) ? 2'b00 : op_mode;
          state_d = (op_mode == 2'b01 || op_mode == 2'b10) ? S_FETCH_LO : S_EXEC;
        end
      end
      S_FETCH_LO: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          tlLoad  = 1'b1;
          pcInc   = 1'b1;
          state_d = S_FETCH_HI;
        end
      end
      S_FETCH_HI: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          thLoad  = 1'b1;
          pcInc   = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sel = 1'b0;
        if (mode_q == 2'b10) begin
          pcLoad  = 1'b1;
          state_d = run ? S_FETCH_OP : S_IDLE;
        end else begin
          arLoad  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_go      = 1'b1;
        mem_addr_sel = 1'b1;
        arInc        = ar_step;
        if (exec_done) state_d = run ? S_FETCH_OP : S_IDLE;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_IDLE;
    endcase
    if (wd_expire) state_d = S_FAULT;
  end

  always_comb begin
    if (!fetch_st || mem_ack || (state_d != state_q)) wd_d = '0;
    else                                              wd_d = wd_q + WDW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      wd_q    <= wd_d;
    end
  end

  assign busy  = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign fault = (state_q == S_FAULT);

endmodule
